avalon_touch_fifo: RTL and testbench

AVALON_TOUCH_FIFO -- requirements
Module: avalon_touch_fifo

---
 rtl/touch_pkg.sv | 42 ++++
 rtl/touch_coord_fifo.sv | 59 +++++
 rtl/avalon_touch_fifo.sv | 195 +++++++++++++++++++
 tb/tb_avalon_touch_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/touch_pkg.sv
// Shared register map, STATUS/CONTROL bit positions and DATA word layout
// for the Avalon touch-panel sample FIFO.
package touch_pkg;

    typedef enum logic [2:0] {
        REG_DATA    = 3'd0,
        REG_STATUS  = 3'd1,
        REG_CONTROL = 3'd2,
        REG_INFO    = 3'd3
    } reg_addr_e;

    localparam int STAT_COUNT_LSB = 0;
    localparam int STAT_COUNT_W   = 7;
    localparam int STAT_EMPTY_BIT = 8;
    localparam int STAT_FULL_BIT  = 9;
    localparam int STAT_OVF_BIT   = 10;
    localparam int STAT_PEN_BIT   = 11;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_IRQ_BIT = 1;
    localparam int CTRL_THR_LSB = 8;
    localparam int CTRL_THR_W   = 7;

    localparam int DATA_VALID_BIT = 31;
    localparam int DATA_Y_LSB     = 16;
    localparam int DATA_X_LSB     = 0;

    localparam int INFO_DEPTH_LSB = 0;
    localparam int INFO_CW_LSB    = 8;
    localparam int INFO_AVG_LSB   = 16;

    // Coordinates arrive zero-extended to the widest legal COORD_W.
    function automatic logic [31:0] pack_data(input logic [14:0] x, input logic [14:0] y);
        logic [31:0] w;
        w                     = '0;
        w[DATA_VALID_BIT]     = 1'b1;
        w[DATA_Y_LSB +: 15]   = y;
        w[DATA_X_LSB +: 15]   = x;
        return w;
    endfunction

endpackage

// File: rtl/touch_coord_fifo.sv
// Power-of-two coordinate FIFO. A push into a full FIFO is accepted only
// when a pop of a valid entry happens in the same cycle.
module touch_coord_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        pop_ok   = pop & ~empty;
        push_ok  = push & (~full | pop_ok);
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/avalon_touch_fifo.sv
// Avalon-MM touch-panel sample FIFO with threshold/overflow interrupt.
// Define TOUCH_AVG_EN to average 2^AVG_LOG2 samples per FIFO entry.
module avalon_touch_fifo
    import touch_pkg::*;
#(
    parameter int COORD_W  = 12,
    parameter int DEPTH    = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               chipselect,
    input  logic               read,
    input  logic               write,
    input  logic [2:0]         address,
    input  logic [31:0]        writedata,
    output logic [31:0]        readdata,
    output logic               int_uc,
    input  logic               sample_valid,
    input  logic [COORD_W-1:0] sample_x,
    input  logic [COORD_W-1:0] sample_y,
    input  logic               pen_down
);

    localparam int CW = $clog2(DEPTH+1);

    logic                  enable_q, enable_d;
    logic                  irq_en_q, irq_en_d;
    logic [CTRL_THR_W-1:0] threshold_q, threshold_d;
    logic                  overflow_q, overflow_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  push, pop, full, empty;
    logic [COORD_W-1:0]    push_x, push_y;
    logic [2*COORD_W-1:0]  pop_data;
    logic [CW-1:0]         count;
    logic [31:0]           status_word, ctrl_word, info_word;
    logic [CTRL_THR_W-1:0] thr_eff;
    logic                  rd_strobe, wr_strobe;
    logic                  unused_cfg;

    assign rd_strobe  = chipselect & read;
    assign wr_strobe  = chipselect & write;
    assign readdata   = readdata_q;
    assign unused_cfg = ^{writedata[31:15], writedata[7:2], 4'(AVG_LOG2)};

`ifdef TOUCH_AVG_EN
    localparam int SW   = COORD_W + AVG_LOG2;
    localparam int CNTW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [SW-1:0]   sum_x_q, sum_x_d, sum_y_q, sum_y_d, sum_x_nx, sum_y_nx;
    logic [CNTW-1:0] smp_cnt_q, smp_cnt_d;

    // The completing sample is pushed in its own cycle, so the sums never hold a full set.
    always_comb begin
        sum_x_d   = sum_x_q;
        sum_y_d   = sum_y_q;
        smp_cnt_d = smp_cnt_q;
        sum_x_nx  = sum_x_q + SW'(sample_x);
        sum_y_nx  = sum_y_q + SW'(sample_y);
        push      = 1'b0;
        push_x    = '0;
        push_y    = '0;
        if (!enable_q || !pen_down) begin
            sum_x_d   = '0;
            sum_y_d   = '0;
            smp_cnt_d = '0;
        end else if (sample_valid) begin
            if (smp_cnt_q == CNTW'(2**AVG_LOG2 - 1)) begin
                push      = 1'b1;
                push_x    = COORD_W'(sum_x_nx >> AVG_LOG2);
                push_y    = COORD_W'(sum_y_nx >> AVG_LOG2);
                sum_x_d   = '0;
                sum_y_d   = '0;
                smp_cnt_d = '0;
            end else begin
                sum_x_d   = sum_x_nx;
                sum_y_d   = sum_y_nx;
                smp_cnt_d = smp_cnt_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sum_x_q   <= '0;
            sum_y_q   <= '0;
            smp_cnt_q <= '0;
        end else begin
            sum_x_q   <= sum_x_d;
            sum_y_q   <= sum_y_d;
            smp_cnt_q <= smp_cnt_d;
        end
    end
`else
    assign push   = sample_valid & enable_q & pen_down;
    assign push_x = sample_x;
    assign push_y = sample_y;
`endif

    touch_coord_fifo #(
        .W     (2*COORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data ({push_y, push_x}),
        .pop       (pop),
        .pop_data  (pop_data),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_comb begin
        status_word                                 = '0;
        status_word[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(count);
        status_word[STAT_EMPTY_BIT]                 = empty;
        status_word[STAT_FULL_BIT]                  = full;
        status_word[STAT_OVF_BIT]                   = overflow_q;
        status_word[STAT_PEN_BIT]                   = pen_down;
        ctrl_word                                   = '0;
        ctrl_word[CTRL_EN_BIT]                      = enable_q;
        ctrl_word[CTRL_IRQ_BIT]                     = irq_en_q;
        ctrl_word[CTRL_THR_LSB +: CTRL_THR_W]       = threshold_q;
        info_word                                   = '0;
        info_word[INFO_DEPTH_LSB +: 8]              = 8'(DEPTH);
        info_word[INFO_CW_LSB +: 8]                 = 8'(COORD_W);
`ifdef TOUCH_AVG_EN
        info_word[INFO_AVG_LSB +: 4]                = 4'(AVG_LOG2);
`endif
    end

    // A dropped push (full, no pop this cycle) outranks a same-cycle overflow clear.
    always_comb begin
        readdata_d  = readdata_q;
        pop         = 1'b0;
        enable_d    = enable_q;
        irq_en_d    = irq_en_q;
        threshold_d = threshold_q;
        overflow_d  = overflow_q;
        if (rd_strobe) begin
            case (address)
                REG_DATA: begin
                    if (!empty) begin
                        readdata_d = pack_data(15'(pop_data[COORD_W-1:0]),
                                               15'(pop_data[2*COORD_W-1:COORD_W]));
                        pop        = 1'b1;
                    end else begin
                        readdata_d = '0;
                    end
                end
                REG_STATUS:  readdata_d = status_word;
                REG_CONTROL: readdata_d = ctrl_word;
                REG_INFO:    readdata_d = info_word;
                default:     readdata_d = '0;
            endcase
        end
        if (wr_strobe) begin
            case (address)
                REG_STATUS: begin
                    if (writedata[STAT_OVF_BIT]) overflow_d = 1'b0;
                end
                REG_CONTROL: begin
                    enable_d    = writedata[CTRL_EN_BIT];
                    irq_en_d    = writedata[CTRL_IRQ_BIT];
                    threshold_d = writedata[CTRL_THR_LSB +: CTRL_THR_W];
                end
                default: ;
            endcase
        end
        if (push && full && !pop) overflow_d = 1'b1;
    end

    assign thr_eff = (threshold_q == '0) ? CTRL_THR_W'(1) : threshold_q;
    assign int_uc  = irq_en_q & ((8'(count) >= 8'(thr_eff)) | overflow_q);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            enable_q    <= 1'b0;
            irq_en_q    <= 1'b0;
            threshold_q <= '0;
            overflow_q  <= 1'b0;
            readdata_q  <= '0;
        end else begin
            enable_q    <= enable_d;
            irq_en_q    <= irq_en_d;
            threshold_q <= threshold_d;
            overflow_q  <= overflow_d;
            readdata_q  <= readdata_d;
        end
    end

endmodule

// File: tb/tb_avalon_touch_fifo.sv
// Scoreboard bench for avalon_touch_fifo; expectations follow TOUCH_AVG_EN.
module tb_avalon_touch_fifo;

    localparam int COORD_W  = 12;
    localparam int DEPTH    = 8;
    localparam int AVG_LOG2 = 2;
`ifdef TOUCH_AVG_EN
    localparam int N_AVG     = 4;
    localparam int INFO_AVG  = 2;
`else
    localparam int N_AVG     = 1;
    localparam int INFO_AVG  = 0;
`endif
    localparam logic [2:0] A_DATA = 3'd0, A_STATUS = 3'd1, A_CONTROL = 3'd2, A_INFO = 3'd3;

    logic               clock, reset_n;
    logic               chipselect, read, write;
    logic [2:0]         address;
    logic [31:0]        writedata, readdata;
    logic               int_uc;
    logic               sample_valid, pen_down;
    logic [COORD_W-1:0] sample_x, sample_y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] exp_q[$];
    logic        rd_seen;

    avalon_touch_fifo #(
        .COORD_W  (COORD_W),
        .DEPTH    (DEPTH),
        .AVG_LOG2 (AVG_LOG2)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .read         (read),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .int_uc       (int_uc),
        .sample_valid (sample_valid),
        .sample_x     (sample_x),
        .sample_y     (sample_y),
        .pen_down     (pen_down)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Monitor: a read strobe seen at a rising edge produces readdata checked on the next falling edge.
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) rd_seen <= 1'b0;
        else          rd_seen <= chipselect && read;
    end

    always @(negedge clock) begin
        exp_t e;
        if (rd_seen && reset_n) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_read: readdata=%h with nothing queued", readdata);
            end else begin
                e = sb_q.pop_front();
                if (readdata !== e.value) begin
                    errors++;
                    $display("[TB] FAIL %s: readdata=%h expected %h", e.name, readdata, e.value);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] status_word(int cnt, bit ovf, bit pen);
        logic [31:0] w;
        w        = 32'(cnt) & 32'h7F;
        w[8]     = (cnt == 0);
        w[9]     = (cnt == DEPTH);
        w[10]    = ovf;
        w[11]    = pen;
        return w;
    endfunction

    function automatic logic [31:0] entry_word(int x, int y);
        return 32'h8000_0000 | (32'(y) << 16) | 32'(x);
    endfunction

    task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_write(logic [2:0] a, logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(posedge clock); #1;
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_read(logic [2:0] a, logic [31:0] exp, string name);
        chipselect = 1'b1; read = 1'b1; address = a;
        sb_q.push_back('{exp, name});
        @(posedge clock); #1;
        chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic send_sample(int x, int y);
        sample_valid = 1'b1; sample_x = COORD_W'(x); sample_y = COORD_W'(y);
        @(posedge clock); #1;
        sample_valid = 1'b0;
    endtask

    task automatic push_entry(int x, int y);
        repeat (N_AVG) send_sample(x, y);
    endtask

    task automatic push_entry_with_read(int x, int y, logic [31:0] exp, string name);
        repeat (N_AVG - 1) send_sample(x, y);
        sample_valid = 1'b1; sample_x = COORD_W'(x); sample_y = COORD_W'(y);
        chipselect = 1'b1; read = 1'b1; address = A_DATA;
        sb_q.push_back('{exp, name});
        @(posedge clock); #1;
        sample_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    endtask

    task automatic drain(string name, bit ovf);
        bus_read(A_STATUS, status_word(exp_q.size(), ovf, pen_down), {name, "_status"});
        while (exp_q.size() > 0) bus_read(A_DATA, exp_q.pop_front(), name);
    endtask

    initial begin
        chipselect = 0; read = 0; write = 0; address = 0; writedata = 0;
        sample_valid = 0; sample_x = 0; sample_y = 0; pen_down = 0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_output("reset_readdata", readdata, 32'h0);
        check_output("reset_int_uc", 32'(int_uc), 32'h0);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;

        bus_read(A_DATA, 32'h0, "data_after_reset");
        bus_read(A_STATUS, 32'h0000_0100, "reset_status");
        bus_read(A_CONTROL, 32'h0, "reset_control");
        bus_read(A_INFO, 32'h0000_0C08 | (32'(INFO_AVG) << 16), "info");
        bus_write(3'd6, 32'hFFFF_FFFF);
        bus_read(3'd6, 32'h0, "unmapped_read");

        // Samples while disabled or pen up are ignored
        pen_down = 1'b1;
        repeat (4) send_sample(7, 8);
        pen_down = 1'b0;
        bus_write(A_CONTROL, 32'h1);
        repeat (4) send_sample(7, 8);
        bus_read(A_STATUS, status_word(0, 0, 0), "ignored_samples");

        // Four samples averaged into one entry
        pen_down = 1'b1;
        for (int i = 0; i < 4; i++) send_sample(100 + 2*i, 200);
`ifdef TOUCH_AVG_EN
        exp_q.push_back(32'h80C8_0067);
`else
        for (int i = 0; i < 4; i++) exp_q.push_back(entry_word(100 + 2*i, 200));
`endif
        drain("avg_entry", 1'b0);

        // Partial accumulation discarded on pen lift
        send_sample(10, 20);
        send_sample(10, 20);
        pen_down = 1'b0;
        @(posedge clock); #1;
        pen_down = 1'b1;
        repeat (4) send_sample(50, 60);
`ifdef TOUCH_AVG_EN
        exp_q.push_back(entry_word(50, 60));
`else
        repeat (2) exp_q.push_back(entry_word(10, 20));
        repeat (4) exp_q.push_back(entry_word(50, 60));
`endif
        drain("pen_lift", 1'b0);

        // Nine pushes into eight slots
        for (int i = 0; i < 9; i++) push_entry(i, 256 + i);
        bus_read(A_STATUS, 32'h0000_0E08, "full_overflow_status");
        bus_write(A_CONTROL, 32'h3);
        check_output("int_full_irq", 32'(int_uc), 32'h1);
        bus_write(A_STATUS, 32'h400);
        bus_read(A_STATUS, 32'h0000_0A08, "overflow_cleared");

        // Push and pop together while full
        push_entry_with_read(9, 265, entry_word(0, 256), "full_push_pop_oldest");
        bus_read(A_STATUS, 32'h0000_0A08, "full_push_pop_status");
        for (int i = 1; i < 8; i++) exp_q.push_back(entry_word(i, 256 + i));
        exp_q.push_back(entry_word(9, 265));
        drain("after_full_push_pop", 1'b0);
        bus_read(A_STATUS, 32'h0000_0900, "drained_status");

        // Empty read and threshold interrupt
        bus_write(A_CONTROL, 32'h0303);
        bus_read(A_CONTROL, 32'h0000_0303, "control_readback");
        bus_read(A_DATA, 32'h0, "empty_data_read");
        bus_read(A_STATUS, 32'h0000_0900, "empty_read_count");
        check_output("int_thr3_0", 32'(int_uc), 32'h0);
        push_entry(1, 2);
        push_entry(3, 4);
        check_output("int_thr3_2", 32'(int_uc), 32'h0);
        push_entry(5, 6);
        check_output("int_thr3_3", 32'(int_uc), 32'h1);

        // Asynchronous reset with entries present
        bus_read(A_STATUS, 32'h0000_0803, "pre_reset_status");
        @(negedge clock); #2;
        reset_n = 1'b0;
        #1;
        check_output("async_reset_int_uc", 32'(int_uc), 32'h0);
        check_output("async_reset_readdata", readdata, 32'h0);
        @(posedge clock);
        @(negedge clock) reset_n = 1'b1;
        @(posedge clock); #1;
        bus_read(A_CONTROL, 32'h0, "control_after_reset");
        bus_read(A_STATUS, 32'h0000_0900, "status_after_reset");
        bus_read(A_DATA, 32'h0, "data_after_mid_reset");
        check_output("int_after_reset", 32'(int_uc), 32'h0);

        repeat (2) @(posedge clock);
        #1;
        check_output("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
